// File: rtl/ahb_split_ctrl.sv
// AHB split controller fronting one shared backend; optional SPLIT_STATS_EN adds split_count/split_pending.
// Latency: HREADYOUT rises in the res_ack cycle; WAIT_LIMIT-1 low cycles, then a two-cycle SPLIT.
// Backpressure: holds HREADYOUT low while the backend is busy; split masters are released via HSPLITx on res_idle.
module ahb_split_ctrl #(
    parameter int WAIT_LIMIT  = 4,
    parameter int NUM_MASTERS = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HSEL,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    input  logic [3:0]             HMASTER,
    input  logic                   HMASTLOCK,
    output logic                   HREADYOUT,
    output logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HSPLITx,
    output logic                   res_req,
    output logic [3:0]             res_master,
    input  logic                   res_ack,
    input  logic                   res_idle
`ifdef SPLIT_STATS_EN
    ,
    output logic [15:0]            split_count,
    output logic                   split_pending
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SPLIT1 = 2'd2,
        ST_SPLIT2 = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             master_q, master_d;
    logic                   lock_q, lock_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;
    logic [NUM_MASTERS-1:0] hsplit_q, hsplit_d;
    logic                   accept;
    logic                   limit_hit;
    logic                   unused_htrans0;

    assign accept         = HSEL & HREADY & HTRANS[1];
    assign unused_htrans0 = HTRANS[0];
    // Compare the post-increment count so the last WAIT cycle is WAIT_LIMIT-1 low cycles in.
    assign limit_hit      = ({1'b0, cnt_q} + 9'd1) >= 9'(WAIT_LIMIT - 1);

    always_comb begin
        state_d   = state_q;
        master_d  = master_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        res_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_WAIT;
                    master_d = HMASTER;
                    lock_d   = HMASTLOCK;
                    cnt_d    = 8'd0;
                end
            end
            ST_WAIT: begin
                res_req   = 1'b1;
                HREADYOUT = res_ack;
                if (res_ack) begin
                    if (accept) begin
                        master_d = HMASTER;
                        lock_d   = HMASTLOCK;
                        cnt_d    = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!lock_q && limit_hit) begin
                    state_d = ST_SPLIT1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SPLIT1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b11;
                state_d   = ST_SPLIT2;
            end
            ST_SPLIT2: begin
                HRESP   = 2'b11;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A bit recorded in SPLIT1 must survive a release happening in the same cycle.
    always_comb begin
        hsplit_d = '0;
        mask_d   = mask_q;
        if (res_idle && (|mask_q)) begin
            hsplit_d = mask_q;
            mask_d   = '0;
        end
        if (state_q == ST_SPLIT1) begin
            mask_d[master_q] = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            master_q <= 4'd0;
            lock_q   <= 1'b0;
            cnt_q    <= 8'd0;
            mask_q   <= '0;
            hsplit_q <= '0;
        end else begin
            state_q  <= state_d;
            master_q <= master_d;
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            hsplit_q <= hsplit_d;
        end
    end

    assign HSPLITx    = hsplit_q;
    assign res_master = master_q;

`ifdef SPLIT_STATS_EN
    logic [15:0] split_cnt_q, split_cnt_d;

    always_comb begin
        split_cnt_d = split_cnt_q;
        if ((state_q == ST_WAIT) && (state_d == ST_SPLIT1) && (split_cnt_q != 16'hFFFF)) begin
            split_cnt_d = split_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            split_cnt_q <= 16'd0;
        end else begin
            split_cnt_q <= split_cnt_d;
        end
    end

    assign split_count   = split_cnt_q;
    assign split_pending = |mask_q;
`endif

endmodule

// File: tb/tb_ahb_split_ctrl.sv
// Randomized self-checking bench for ahb_split_ctrl against a transaction-level model.
// Single-slave bus: HREADY is looped back from HREADYOUT.
module tb_ahb_split_ctrl;

    localparam int WL = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [3:0]  HMASTER;
    logic        HMASTLOCK;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [15:0] HSPLITx;
    logic        res_req;
    logic [3:0]  res_master;
    logic        res_ack;
    logic        res_idle;
`ifdef SPLIT_STATS_EN
    logic [15:0] split_count;
    logic        split_pending;
`endif

    ahb_split_ctrl #(.WAIT_LIMIT(WL), .NUM_MASTERS(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
        .HREADY(HREADY), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HSPLITx(HSPLITx),
        .res_req(res_req), .res_master(res_master),
        .res_ack(res_ack), .res_idle(res_idle)
`ifdef SPLIT_STATS_EN
        , .split_count(split_count), .split_pending(split_pending)
`endif
    );

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    int          total = 0;
    int          bad = 0;
    int          n_splits = 0;
    logic [15:0] pend = 16'h0;
    logic [15:0] exp_hs = 16'h0;
    bit          rnd_idle = 1'b0;

    // Release rule: an idle cycle hands the recorded set out next cycle and empties it;
    // a master split this cycle is recorded afterwards, so it waits for a later idle cycle.
    task automatic model_end(input bit idle, input bit set_vld, input logic [3:0] m);
        exp_hs = idle ? pend : 16'h0;
        if (idle) pend = 16'h0;
        if (set_vld) begin
            pend[m] = 1'b1;
            n_splits++;
        end
    endtask

    function automatic bit pick_idle();
        return rnd_idle ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic idle_cycle(input bit idle, input string tag);
        @(posedge HCLK); #1;
        HSEL = 1'($urandom_range(0, 1));
        HTRANS = {1'b0, 1'($urandom_range(0, 1))};
        HMASTER = 4'($urandom_range(0, 15));
        res_ack = 1'($urandom_range(0, 1));
        res_idle = idle;
        @(negedge HCLK);
        total++;
        if (HREADYOUT !== 1'b1 || HRESP !== 2'b00 || res_req !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_outputs: rdy=%0b resp=%0d req=%0b want 1/0/0", tag, HREADYOUT, HRESP, res_req);
        end
        total++;
        if (HSPLITx !== exp_hs) begin
            bad++;
            $display("FAIL %s hsplit: got %h want %h", tag, HSPLITx, exp_hs);
        end
`ifdef SPLIT_STATS_EN
        total++;
        if (split_pending !== (pend != 16'h0)) begin
            bad++;
            $display("FAIL %s split_pending: got %0b want %0b", tag, split_pending, pend != 16'h0);
        end
`endif
        model_end(idle, 1'b0, 4'd0);
    endtask

    task automatic addr_phase(input logic [3:0] m, input bit lk, input string tag);
        bit idle;
        @(posedge HCLK); #1;
        idle = pick_idle();
        HSEL = 1'b1;
        HTRANS = {1'b1, 1'($urandom_range(0, 1))};
        HMASTER = m;
        HMASTLOCK = lk;
        res_ack = 1'($urandom_range(0, 1));
        res_idle = idle;
        @(negedge HCLK);
        total++;
        if (HREADYOUT !== 1'b1 || HRESP !== 2'b00 || res_req !== 1'b0) begin
            bad++;
            $display("FAIL %s addr_outputs: rdy=%0b resp=%0d req=%0b want 1/0/0", tag, HREADYOUT, HRESP, res_req);
        end
        total++;
        if (HSPLITx !== exp_hs) begin
            bad++;
            $display("FAIL %s addr_hsplit: got %h want %h", tag, HSPLITx, exp_hs);
        end
        model_end(idle, 1'b0, 4'd0);
    endtask

    // d = number of ack-free data cycles the backend would take.
    task automatic data_phase(input logic [3:0] m, input bit lk, input int d, input bit b2b,
                              input logic [3:0] m2, input bit lk2, input string tag);
        bit split;
        bit idle;
        bit last;
        int nw;
        split = !lk && (d >= WL - 1);
        nw = split ? WL - 1 : d + 1;
        for (int k = 0; k < nw; k++) begin
            last = !split && (k == d);
            @(posedge HCLK); #1;
            idle = pick_idle();
            res_idle = idle;
            res_ack = last;
            if (last && b2b) begin
                HSEL = 1'b1; HTRANS = 2'b10; HMASTER = m2; HMASTLOCK = lk2;
            end else begin
                HSEL = 1'($urandom_range(0, 1));
                HTRANS = {1'b0, 1'($urandom_range(0, 1))};
                HMASTER = 4'($urandom_range(0, 15));
                HMASTLOCK = 1'($urandom_range(0, 1));
            end
            @(negedge HCLK);
            total++;
            if (HREADYOUT !== last || HRESP !== 2'b00) begin
                bad++;
                $display("FAIL %s wait%0d: rdy=%0b resp=%0d want %0b/0", tag, k, HREADYOUT, HRESP, last);
            end
            total++;
            if (res_req !== 1'b1 || res_master !== m) begin
                bad++;
                $display("FAIL %s wait%0d_req: req=%0b master=%0d want 1/%0d", tag, k, res_req, res_master, m);
            end
            total++;
            if (HSPLITx !== exp_hs) begin
                bad++;
                $display("FAIL %s wait%0d_hsplit: got %h want %h", tag, k, HSPLITx, exp_hs);
            end
            model_end(idle, 1'b0, m);
        end
        if (split) begin
            @(posedge HCLK); #1;
            idle = pick_idle();
            res_idle = idle;
            res_ack = 1'($urandom_range(0, 1));
            HSEL = 1'b0; HTRANS = 2'b00;
            @(negedge HCLK);
            total++;
            if (HREADYOUT !== 1'b0 || HRESP !== 2'b11 || res_req !== 1'b0) begin
                bad++;
                $display("FAIL %s split1: rdy=%0b resp=%0d req=%0b want 0/3/0", tag, HREADYOUT, HRESP, res_req);
            end
            total++;
            if (HSPLITx !== exp_hs) begin
                bad++;
                $display("FAIL %s split1_hsplit: got %h want %h", tag, HSPLITx, exp_hs);
            end
            model_end(idle, 1'b1, m);
            @(posedge HCLK); #1;
            idle = pick_idle();
            res_idle = idle;
            res_ack = 1'b0;
            HSEL = 1'b1; HTRANS = 2'b10; HMASTER = 4'($urandom_range(0, 15));
            @(negedge HCLK);
            total++;
            if (HREADYOUT !== 1'b1 || HRESP !== 2'b11 || res_req !== 1'b0) begin
                bad++;
                $display("FAIL %s split2: rdy=%0b resp=%0d req=%0b want 1/3/0", tag, HREADYOUT, HRESP, res_req);
            end
            total++;
            if (HSPLITx !== exp_hs) begin
                bad++;
                $display("FAIL %s split2_hsplit: got %h want %h", tag, HSPLITx, exp_hs);
            end
            model_end(idle, 1'b0, m);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00; HMASTER = 4'd0; HMASTLOCK = 1'b0;
        res_ack = 1'b0; res_idle = 1'b0;
        repeat (2) @(negedge HCLK);
        total++;
        if (HREADYOUT !== 1'b1 || HRESP !== 2'b00 || HSPLITx !== 16'h0 || res_req !== 1'b0 || res_master !== 4'd0) begin
            bad++;
            $display("FAIL reset_values: rdy=%0b resp=%0d hs=%h req=%0b master=%0d", HREADYOUT, HRESP, HSPLITx, res_req, res_master);
        end
`ifdef SPLIT_STATS_EN
        total++;
        if (split_count !== 16'd0 || split_pending !== 1'b0) begin
            bad++;
            $display("FAIL reset_stats: count=%0d pending=%0b want 0/0", split_count, split_pending);
        end
`endif
        HRESETn = 1'b1;
        pend = 16'h0; exp_hs = 16'h0; n_splits = 0;
    endtask

    task automatic test_ack_first();
        addr_phase(4'd2, 1'b0, "ack_first");
        data_phase(4'd2, 1'b0, 0, 1'b0, 4'd0, 1'b0, "ack_first");
    endtask

    task automatic test_split();
        addr_phase(4'd5, 1'b0, "split");
        data_phase(4'd5, 1'b0, WL + 3, 1'b0, 4'd0, 1'b0, "split");
    endtask

    task automatic test_release();
        total++;
        if (pend !== 16'h0020) begin
            bad++;
            $display("FAIL release_setup: model set %h want 0020", pend);
        end
        idle_cycle(1'b1, "release_a");
        idle_cycle(1'b1, "release_b");
        idle_cycle(1'b0, "release_c");
    endtask

    task automatic test_locked();
        addr_phase(4'd1, 1'b1, "locked");
        data_phase(4'd1, 1'b1, 10, 1'b0, 4'd0, 1'b0, "locked");
    endtask

    task automatic test_ack_at_limit();
        addr_phase(4'd3, 1'b0, "ack_limit");
        data_phase(4'd3, 1'b0, WL - 2, 1'b1, 4'd6, 1'b0, "ack_limit");
        data_phase(4'd6, 1'b0, 1, 1'b0, 4'd0, 1'b0, "b2b");
    endtask

    task automatic test_random();
        bit inflt;
        bit split;
        bit b2b;
        bit lk;
        bit lk2;
        int d;
        logic [3:0] m;
        logic [3:0] m2;
        rnd_idle = 1'b1;
        inflt = 1'b0;
        m = 4'($urandom_range(0, 15));
        lk = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 40; i++) begin
            if (!inflt) addr_phase(m, lk, "rand_addr");
            d = $urandom_range(0, 7);
            split = !lk && (d >= WL - 1);
            b2b = !split && (i < 39) && ($urandom_range(0, 1) == 1);
            m2 = 4'($urandom_range(0, 15));
            lk2 = ($urandom_range(0, 3) == 0);
            data_phase(m, lk, d, b2b, m2, lk2, "rand_data");
            inflt = b2b;
            if (!b2b) repeat ($urandom_range(0, 2)) idle_cycle(pick_idle(), "rand_gap");
            m = b2b ? m2 : 4'($urandom_range(0, 15));
            lk = b2b ? lk2 : ($urandom_range(0, 3) == 0);
        end
        idle_cycle(1'b1, "rand_flush");
        idle_cycle(1'b1, "rand_flush");
        rnd_idle = 1'b0;
`ifdef SPLIT_STATS_EN
        total++;
        if (split_count !== 16'(n_splits)) begin
            bad++;
            $display("FAIL split_count: got %0d want %0d", split_count, n_splits);
        end
`endif
    endtask

    task automatic test_reset_mid_split();
        addr_phase(4'd7, 1'b0, "rst_split");
        for (int k = 0; k < WL - 1; k++) begin
            @(posedge HCLK); #1;
            res_ack = 1'b0; res_idle = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
        end
        @(posedge HCLK); #1;
        total++;
        if (HRESP !== 2'b11 || HREADYOUT !== 1'b0) begin
            bad++;
            $display("FAIL rst_split_enter: rdy=%0b resp=%0d want 0/3", HREADYOUT, HRESP);
        end
        #2;
        HRESETn = 1'b0;
        res_idle = 1'b1;
        #1;
        total++;
        if (HREADYOUT !== 1'b1 || HRESP !== 2'b00 || HSPLITx !== 16'h0 || res_req !== 1'b0 || res_master !== 4'd0) begin
            bad++;
            $display("FAIL rst_split_values: rdy=%0b resp=%0d hs=%h req=%0b master=%0d", HREADYOUT, HRESP, HSPLITx, res_req, res_master);
        end
        pend = 16'h0; exp_hs = 16'h0; n_splits = 0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (3) idle_cycle(1'b1, "rst_split_idle");
`ifdef SPLIT_STATS_EN
        total++;
        if (split_count !== 16'd0) begin
            bad++;
            $display("FAIL rst_split_count: got %0d want 0", split_count);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ack_first();
        test_split();
        test_release();
        test_locked();
        test_ack_at_limit();
        test_random();
        test_reset_mid_split();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_split_ctrl.md
Name: ahb_split_ctrl

Overview:
- AHB slave-side split controller that fronts a single shared backend resource (one transfer in service at a time).
- Inserts wait states while the resource is busy.
- Once a wait limit is reached, it ends the transfer with a two-cycle SPLIT response and records the master.
- When the resource goes idle, it releases the recorded masters through HSPLITx back to ahb_arbiter.

Parameters:
- WAIT_LIMIT, 4, number of data-phase wait cycles without res_ack before a SPLIT is issued (legal 1..255).
- NUM_MASTERS, 16, width of the split mask and HSPLITx; the HMASTER index must be < NUM_MASTERS.

Ports:
- HCLK  in  1  clock, all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HTRANS  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HREADY  in  1  bus-level ready
- HMASTER  in  4  current master index from ahb_arbiter
- HMASTLOCK  in  1  locked sequence indicator
- HREADYOUT  out  1  slave ready
- HRESP  out  2  response (00 OKAY, 11 SPLIT)
- HSPLITx  out  NUM_MASTERS  one-cycle release pulses to ahb_arbiter HSPLIT
- res_req  out  1  service request to backend resource
- res_master  out  4  master index of the transfer in service
- res_ack  in  1  backend completes the requested transfer this cycle
- res_idle  in  1  backend is able to accept work

Behaviour:
- Reset (async, HRESETn=0):
  - HREADYOUT=1, HRESP=00, HSPLITx=0, res_req=0, res_master=0.
  - State IDLE, wait counter 0, split mask 0.
  - Reset mid-transfer or mid-SPLIT aborts the transfer; recorded masters are lost and no HSPLITx is emitted.
- Address phase accept: HSEL & HREADY & HTRANS[1] at a rising edge. HMASTER and HMASTLOCK are latched, counter cleared, next state WAIT.
- IDLE/BUSY transfers, or HSEL=0: no state change; zero-wait OKAY.
- States:
  - IDLE:
    - HREADYOUT=1, HRESP=OKAY, res_req=0.
    - Accept -> WAIT.
  - WAIT:
    - res_req=1, res_master=latched index, HRESP=OKAY, HREADYOUT=res_ack (combinational).
    - res_ack=1: transfer completes with zero extra waits. A new address phase accepted in that cycle stays in WAIT with the counter cleared; otherwise -> IDLE.
    - res_ack=0: counter increments.
    - Counter==WAIT_LIMIT-1 with res_ack=0 and latched lock=0 -> SPLIT1.
    - Latched lock=1: never split; waits indefinitely.
    - Simultaneous res_ack and limit reached: the ack wins, completing OKAY.
  - SPLIT1:
    - HREADYOUT=0, HRESP=11, res_req=0.
    - Sets the mask bit for the latched master.
    - Always -> SPLIT2.
  - SPLIT2:
    - HREADYOUT=1, HRESP=11, res_req=0.
    - Address phases in this cycle are ignored, since the master must cancel them.
    - -> IDLE.
- Backend rules:
  - The backend must not raise res_ack while res_req=0; such an ack is ignored.
  - After a SPLIT the transfer is considered not performed.
- Release: when res_idle=1 and mask!=0, registered HSPLITx=mask for exactly one cycle, then the mask is cleared.
  - A mask set in the same cycle as a release (SPLIT1) survives the clear; set has priority for that bit.
  - HSPLITx is never asserted for a master whose SPLIT2 has not completed.
  - Release may repeat on later idle cycles for newly recorded masters.
- A transfer from a master whose bit is already set is serviced normally; the bit is unaffected.
- HREADYOUT latency: 1 + number of res_ack-free cycles. Max waits before SPLIT is WAIT_LIMIT-1 low cycles plus the SPLIT1 cycle.

Optional Feature:
- Macro SPLIT_STATS_EN.
- When defined:
  - Adds output split_count (16 bits).
  - Increments by 1 on each SPLIT1 entry and saturates at 16'hFFFF.
  - Cleared by reset only.
  - Adds output split_pending = |mask.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset, then NONSEQ from master 2 with res_ack in the first data cycle -> HREADYOUT=1, HRESP=00 in that cycle; res_master=2; no HSPLITx.
- WAIT_LIMIT=4, master 5 NONSEQ, res_ack held 0 -> 3 data cycles HREADYOUT=0/OKAY, then SPLIT1 (0/11), then SPLIT2 (1/11); mask bit 5 set; res_req drops at SPLIT1.
- After the previous case, res_idle=1 -> HSPLITx=16'h0020 for exactly one cycle, then 0; a second idle cycle gives no pulse.
- Locked transfer (HMASTLOCK=1) from master 1, res_ack delayed 10 cycles -> 10 cycles HREADYOUT=0/OKAY, then OKAY completion; no SPLIT.
- res_ack arriving in the cycle the counter reaches the limit -> OKAY completion, no SPLIT; back-to-back pipelined NONSEQ accepted that cycle.
- HRESETn asserted during SPLIT1 for master 7 -> all outputs return to reset values immediately; HSPLITx stays 0 after release even with res_idle=1. With SPLIT_STATS_EN, split_count is 0 after reset.
